// File: rtl/line_steer_fsm.sv
// Line-following steering controller: filtered N-bit sensor array, six-state FSM, PWM motor gating.
// Optional build macro LINE_STEER_TURN_BOOST_EN drives the outer motor at full power while turning/searching.
module line_steer_fsm #(
    parameter int N_SENS     = 4,
    parameter int FILTER     = 3,
    parameter int SEARCH_MAX = 255,
    parameter int DUTY_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_SENS-1:0] sens,
    input  logic [DUTY_W-1:0] duty,
    output logic              left,
    output logic              right,
    output logic [2:0]        state,
    output logic              lost
);
    localparam int HALF = N_SENS / 2;
    localparam int FCW  = $clog2(FILTER + 1);
    localparam int SCW  = $clog2(SEARCH_MAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FWD    = 3'd1,
        TURN_L = 3'd2,
        TURN_R = 3'd3,
        SEARCH = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [N_SENS-1:0]  s_q, cand_q, filt_q;
    logic [FCW-1:0]     fcnt_q;
    logic [SCW-1:0]     scnt_q;
    logic [DUTY_W-1:0]  pwm_cnt_q;
    logic               last_dir_q;
    logic               side_l, side_r, timeout, pwm_on, turn_drive;

    // cand_q/fcnt_q track how long s_q has held one value; filt_q only moves once that run reaches FILTER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cand_q <= '0;
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            s_q <= sens;
            if (s_q == cand_q) begin
                if (fcnt_q != FCW'(FILTER))
                    fcnt_q <= fcnt_q + FCW'(1);
                if (int'(fcnt_q) + 1 >= FILTER)
                    filt_q <= s_q;
            end else begin
                cand_q <= s_q;
                fcnt_q <= FCW'(1);
                if (FILTER == 1)
                    filt_q <= s_q;
            end
        end
    end

    assign side_l  = |filt_q[N_SENS-1:HALF];
    assign side_r  = |filt_q[HALF-1:0];
    assign timeout = (scnt_q == SCW'(SEARCH_MAX - 1));

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = FWD;
                FWD, TURN_L, TURN_R, SEARCH: begin
                    if (side_l && side_r)                 state_d = FWD;
                    else if (side_l)                      state_d = TURN_L;
                    else if (side_r)                      state_d = TURN_R;
                    else if (state_q == SEARCH && timeout) state_d = STOP;
                    else                                  state_d = SEARCH;
                end
                STOP:    state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            scnt_q     <= '0;
            last_dir_q <= 1'b0;
            pwm_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pwm_cnt_q <= pwm_cnt_q + DUTY_W'(1);
            // Search count restarts on every entry so a brief sensor hit grants a fresh timeout window.
            if (state_d == SEARCH && state_q != SEARCH)
                scnt_q <= '0;
            else if (state_d == SEARCH)
                scnt_q <= scnt_q + SCW'(1);
            if (state_d == TURN_L)
                last_dir_q <= 1'b0;
            else if (state_d == TURN_R)
                last_dir_q <= 1'b1;
        end
    end

    assign pwm_on = (pwm_cnt_q < duty);

`ifdef LINE_STEER_TURN_BOOST_EN
    assign turn_drive = 1'b1;
`else
    assign turn_drive = pwm_on;
`endif

    always_comb begin
        left  = 1'b0;
        right = 1'b0;
        case (state_q)
            FWD: begin
                left  = pwm_on;
                right = pwm_on;
            end
            TURN_L: right = turn_drive;
            TURN_R: left  = turn_drive;
            SEARCH: begin
                if (last_dir_q) left  = turn_drive;
                else            right = turn_drive;
            end
            default: ;
        endcase
    end

    assign state = state_q;
    assign lost  = (state_q == STOP);

endmodule

// File: tb/tb_line_steer_fsm.sv
// Directed bench for line_steer_fsm: filter latency, steering, search timeout, async reset, PWM duty.
module tb_line_steer_fsm;
    localparam int N_SENS     = 4;
    localparam int FILTER     = 3;
    localparam int SEARCH_MAX = 8;
    localparam int DUTY_W     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [N_SENS-1:0] sens;
    logic [DUTY_W-1:0] duty;
    logic              left, right, lost;
    logic [2:0]        state;

    int checks = 0;
    int errors = 0;
    int pcnt   = 0;
    int highs;

    line_steer_fsm #(
        .N_SENS(N_SENS), .FILTER(FILTER), .SEARCH_MAX(SEARCH_MAX), .DUTY_W(DUTY_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sens(sens), .duty(duty),
        .left(left), .right(right), .state(state), .lost(lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bench-side PWM counter model: pcnt mirrors edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        pcnt = (pcnt + 1) % 16;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic pwm_exp();
        return (pcnt < int'(duty));
    endfunction

    function automatic logic turn_exp();
`ifdef LINE_STEER_TURN_BOOST_EN
        return 1'b1;
`else
        return pwm_exp();
`endif
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; sens = '0; duty = 4'd8;
        #2;
        check("rst_state", 32'(state), 0);
        check("rst_left", 32'(left), 0);
        check("rst_right", 32'(right), 0);
        check("rst_lost", 32'(lost), 0);
        @(posedge clk); #1;
        rst = 1'b0; pcnt = 0;

        // 1: centered line, FWD with in-phase PWM at duty 8/16
        sens = 4'b0110;
        ticks(5);
        check("t1_idle", 32'(state), 0);
        en = 1'b1;
        tick();
        check("t1_fwd", 32'(state), 1);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t1_state", 32'(state), 1);
            check("t1_left", 32'(left), 32'(pwm_exp()));
            check("t1_right", 32'(right), 32'(pwm_exp()));
            if (left && right) highs++;
        end
        check("t1_high_count", 32'(highs), 8);

        // 2: two-sample glitch rejected, then held LEFT pattern turns after FILTER+2 edges
        sens = 4'b1000;
        ticks(2);
        sens = 4'b0110;
        ticks(6);
        check("t2_glitch", 32'(state), 1);
        sens = 4'b1000;
        ticks(4);
        check("t2_not_yet", 32'(state), 1);
        tick();
        check("t2_turn_l", 32'(state), 2);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_left", 32'(left), 0);
            check("t2_right", 32'(right), 32'(turn_exp()));
        end

        // 3: TURN_R, then line lost -> SEARCH toward right, timeout -> sticky STOP
        sens = 4'b0001;
        ticks(4);
        check("t3_still_l", 32'(state), 2);
        tick();
        check("t3_turn_r", 32'(state), 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_tr_left", 32'(left), 32'(turn_exp()));
            check("t3_tr_right", 32'(right), 0);
        end
        sens = 4'b0000;
        ticks(4);
        check("t3_pre_search", 32'(state), 3);
        tick();
        check("t3_search", 32'(state), 4);
        for (int i = 1; i < SEARCH_MAX; i++) begin
            tick();
            check("t3_search_hold", 32'(state), 4);
            check("t3_s_left", 32'(left), 32'(turn_exp()));
            check("t3_s_right", 32'(right), 0);
        end
        tick();
        check("t3_stop", 32'(state), 5);
        check("t3_lost", 32'(lost), 1);
        check("t3_stop_left", 32'(left), 0);
        check("t3_stop_right", 32'(right), 0);
        sens = 4'b0110;
        ticks(6);
        check("t3_sticky", 32'(state), 5);
        check("t3_sticky_l", 32'(left), 0);
        en = 1'b0;
        tick();
        check("t3_idle", 32'(state), 0);
        check("t3_unlost", 32'(lost), 0);

        // 4: re-found line inside SEARCH, then a fresh full timeout window
        en = 1'b1;
        tick();
        check("t4_fwd", 32'(state), 1);
        sens = 4'b0000;
        ticks(4);
        check("t4_pre_search", 32'(state), 1);
        tick();
        check("t4_search", 32'(state), 4);
        sens = 4'b0001;
        ticks(4);
        check("t4_search_hold", 32'(state), 4);
        tick();
        check("t4_turn_r", 32'(state), 3);
        sens = 4'b0000;
        ticks(5);
        check("t4_search2", 32'(state), 4);
        ticks(SEARCH_MAX - 1);
        check("t4_full_window", 32'(state), 4);
        tick();
        check("t4_stop", 32'(state), 5);

        // 5: asynchronous reset mid-cycle in TURN_L, then last_dir back to 0
        en = 1'b0;
        tick();
        sens = 4'b1000;
        ticks(5);
        en = 1'b1;
        tick();
        check("t5_fwd", 32'(state), 1);
        tick();
        check("t5_turn_l", 32'(state), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_async_state", 32'(state), 0);
        check("t5_async_left", 32'(left), 0);
        check("t5_async_right", 32'(right), 0);
        check("t5_async_lost", 32'(lost), 0);
        sens = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0; pcnt = 0;
        tick();
        check("t5_fwd_again", 32'(state), 1);
        tick();
        check("t5_search", 32'(state), 4);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_dir_left", 32'(left), 0);
            check("t5_dir_right", 32'(right), 32'(turn_exp()));
        end

        // 6: duty extremes in FWD, then a TURN_L drive check
        en = 1'b0;
        sens = 4'b0110;
        ticks(5);
        en = 1'b1;
        tick();
        check("t6_fwd", 32'(state), 1);
        duty = 4'd0;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("t6_d0_left", 32'(left), 0);
            check("t6_d0_right", 32'(right), 0);
        end
        duty = 4'd15;
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t6_d15_left", 32'(left), 32'(pwm_exp()));
            if (left && right) highs++;
        end
        check("t6_d15_count", 32'(highs), 15);
        duty = 4'd8;
        sens = 4'b1000;
        ticks(5);
        check("t6_turn_l", 32'(state), 2);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t6_tl_left", 32'(left), 0);
            check("t6_tl_right", 32'(right), 32'(turn_exp()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
